// File: rtl/tinyalu_driver.sv
// Command initiator for the tinyalu start/done handshake: accepts a command, runs it
// on tinyalu with timeout protection, and returns the result on a response channel.
module tinyalu_driver #(
    parameter int TIMEOUT   = 15,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_a,
    input  logic [7:0]           cmd_b,
    input  logic [2:0]           cmd_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic                 alu_start,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_op,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   alu_start_q, alu_start_d;
    logic [7:0]             alu_a_q, alu_a_d;
    logic [7:0]             alu_b_q, alu_b_d;
    logic [2:0]             alu_op_q, alu_op_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [15:0]            rsp_result_q, rsp_result_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [7:0]             tmo_cnt_q, tmo_cnt_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic cmd_accept;
    logic cmd_legal;
    logic tmo_hit;

    // cmd_ready is gated by reset_n so it reads low for the whole reset assertion.
    assign cmd_ready  = reset_n && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign cmd_legal  = (cmd_op != 3'd0) && (cmd_op <= 3'd4);
    assign tmo_hit    = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            alu_start_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            tmo_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            alu_start_q  <= alu_start_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_accept) state_d = cmd_legal ? ISSUE : RESP;
            ISSUE:   if (alu_done || tmo_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Done is checked before the timeout so a completion on the last allowed cycle wins.
    always_comb begin
        alu_start_d  = alu_start_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_legal) begin
                        alu_start_d = 1'b1;
                        alu_a_d     = cmd_a;
                        alu_b_d     = cmd_b;
                        alu_op_d    = cmd_op;
                        tmo_cnt_d   = '0;
                    end else begin
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_err_d    = (cmd_op != 3'd0);
                    end
                end
            end
            ISSUE: begin
                if (alu_done) begin
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    tmo_cnt_d    = '0;
                end else if (tmo_hit) begin
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    tmo_cnt_d    = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign alu_start  = alu_start_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_tinyalu_driver.sv
// Directed self-checking bench for tinyalu_driver, with a small behavioural tinyalu
// (single-cycle ops finish on the 2nd start cycle, mul on the 5th).
module tb_tinyalu_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        alu_start;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        busy;
    logic [7:0]  err_count;

    logic        doneEnable;
    logic [3:0]  startCnt;
    int          errors = 0;
    int          checks = 0;

    tinyalu_driver #(.TIMEOUT(15), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Behavioural tinyalu: counts how long start has been high.
    always_ff @(posedge clk) startCnt <= alu_start ? startCnt + 4'd1 : 4'd0;

    assign alu_done = doneEnable && alu_start &&
                      (startCnt == ((alu_op == 3'd4) ? 4'd4 : 4'd1));

    always_comb begin
        alu_result = 16'h0000;
        case (alu_op)
            3'd1: alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            3'd2: alu_result = {8'h00, alu_a & alu_b};
            3'd3: alu_result = {8'h00, alu_a ^ alu_b};
            3'd4: alu_result = alu_a * alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one command and follow it to its response; hold = cycles rsp_ready stays low.
    task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input int expLat, input int expStarts,
                                 input logic [15:0] expRes, input logic expErr, input int hold);
        int lat, starts;
        bit seen;
        logic [15:0] res;
        logic er;
        @(negedge clk);
        checkOutput({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'd0;
        lat = 0; starts = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (alu_start) starts++;
            if (rsp_valid) seen = 1;
        end
        checkOutput({tag, "_seen"}, 32'(seen), 1);
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_starts"}, starts, expStarts);
        checkOutput({tag, "_result"}, rsp_result, expRes);
        checkOutput({tag, "_err"}, rsp_err, expErr);
        res = rsp_result;
        er  = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "_holdvalid"}, rsp_valid, 1);
            checkOutput({tag, "_holdresult"}, rsp_result, res);
            checkOutput({tag, "_holderr"}, rsp_err, er);
            checkOutput({tag, "_holdready"}, cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_drop"}, rsp_valid, 0);
        checkOutput({tag, "_readyback"}, cmd_ready, 1);
        checkOutput({tag, "_nolaunch"}, alu_start, 0);
    endtask

    // Lightweight timeout run used to drive err_count up to saturation.
    task automatic runTimeout();
        bit seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 8'h01; cmd_b = 8'h01; cmd_op = 3'd1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        if (!seen) checkOutput("tmo_bound", 32'(seen), 1);
        @(posedge clk);
    endtask

    initial begin
        bit stray;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'd0;
        rsp_ready = 1'b0; doneEnable = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_result", rsp_result, 0);
        checkOutput("rst_alu_start", alu_start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_count", err_count, 0);
        reset_n = 1'b1;
        #1 checkOutput("rel_cmd_ready", cmd_ready, 1);

        applyStimulus("add", 8'hFF, 8'h01, 3'd1, 3, 2, 16'h0100, 1'b0, 0);
        applyStimulus("mul", 8'hFF, 8'hFF, 3'd4, 6, 5, 16'hFE01, 1'b0, 0);
        applyStimulus("and", 8'hF0, 8'h3C, 3'd2, 3, 2, 16'h0030, 1'b0, 0);
        applyStimulus("xor", 8'hAA, 8'h55, 3'd3, 3, 2, 16'h00FF, 1'b0, 4);
        applyStimulus("nop", 8'h12, 8'h34, 3'd0, 1, 0, 16'h0000, 1'b0, 0);
        checkOutput("errcnt_before", err_count, 0);
        applyStimulus("illegal", 8'h12, 8'h34, 3'd7, 1, 0, 16'h0000, 1'b1, 0);
        checkOutput("errcnt_after", err_count, 1);

        doneEnable = 1'b0;
        applyStimulus("timeout", 8'h05, 8'h06, 3'd1, 16, 15, 16'h0000, 1'b1, 0);
        checkOutput("errcnt_tmo", err_count, 2);
        for (int i = 0; i < 253; i++) runTimeout();
        @(negedge clk);
        checkOutput("errcnt_full", err_count, 8'hFF);
        for (int i = 0; i < 2; i++) runTimeout();
        @(negedge clk);
        checkOutput("errcnt_sat", err_count, 8'hFF);
        doneEnable = 1'b1;

        // Reset in the middle of a mul: everything must clear without waiting for a clock.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 8'h10; cmd_b = 8'h10; cmd_op = 3'd4; rsp_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_start_pre", alu_start, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_alu_start", alu_start, 0);
        checkOutput("arst_rsp_valid", rsp_valid, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_err_count", err_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || alu_start) stray = 1;
        end
        checkOutput("arst_no_rsp", 32'(stray), 0);
        applyStimulus("post_rst_add", 8'h12, 8'h34, 3'd1, 3, 2, 16'h0046, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tinyalu_driver.md
Name: tinyalu_driver

Overview:
- Command initiator for the tinyalu start/done handshake.
- Accepts ALU commands on a valid/ready input channel and drives tinyalu's start/A/B/op, holding them until done.
- Captures the 16-bit result and returns it on a valid/ready response channel, with timeout protection and illegal-op filtering.
- Sits between a sequencer/CPU-side command source and one tinyalu instance.

Parameters:
- TIMEOUT, 15, max cycles alu_start may stay high without alu_done before abort (1..255).
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, all logic on posedge
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  driver can accept command
- cmd_a  input  8  operand A
- cmd_b  input  8  operand B
- cmd_op  input  3  opcode: 000 nop, 001 add, 010 and, 011 xor, 100 mul, 101-111 illegal
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_result  output  16  result
- rsp_err  output  1  response is illegal-op or timeout
- alu_start  output  1  to tinyalu start
- alu_a  output  8  to tinyalu A
- alu_b  output  8  to tinyalu B
- alu_op  output  3  to tinyalu op
- alu_done  input  1  from tinyalu done
- alu_result  input  16  from tinyalu result
- busy  output  1  state != IDLE
- err_count  output  ERR_CNT_W  saturating count of error responses

Behaviour:
- Reset (async, reset_n low): state IDLE; cmd_ready=0 while reset_n low, 1 from the first cycle after release; rsp_valid=0, rsp_result=0, rsp_err=0; alu_start=0, alu_a/b/op=0; busy=0; err_count=0; timeout counter=0. Reset mid-transaction discards the transaction, with no response.
- All outputs are registered except cmd_ready (= state==IDLE) and busy.
- State IDLE:
  - cmd_valid&cmd_ready on an edge with op 001..100 -> latch a/b/op into alu_a/b/op; alu_start=1 next cycle; go ISSUE.
  - op 000 -> go RESP with result 0, err 0; alu_start is not asserted.
  - op 101..111 -> go RESP with result 0, err 1; alu_start is not asserted.
- State ISSUE:
  - alu_start, alu_a, alu_b, alu_op held stable.
  - Timeout counter increments each cycle.
  - alu_done=1 sampled -> rsp_result<=alu_result, rsp_err<=0, alu_start<=0 at the same edge, counter cleared, go RESP.
  - This guarantees start is low in tinyalu's following READY cycle, so there is no double launch.
  - Counter reaches TIMEOUT without done -> alu_start<=0, rsp_result<=0, rsp_err<=1, go RESP.
  - If done and the final timeout cycle coincide, done wins (no error).
- State RESP:
  - rsp_valid=1; rsp_result/rsp_err stable until rsp_valid&rsp_ready at an edge.
  - On that handshake: rsp_valid<=0, go IDLE.
  - A new command cannot be accepted in the same cycle; there is at least one IDLE cycle between responses.
- alu_done seen while not in ISSUE is ignored.
- err_count increments on each accepted error response (rsp_valid&rsp_ready&rsp_err) and saturates at all-ones.
- Latency (cmd handshake edge = end of cycle 0, rsp_ready held 1):
  - add/and/xor: alu_start high cycles 1-2, done in cycle 2, rsp_valid cycle 3.
  - mul: alu_start high cycles 1-5, done in cycle 5, rsp_valid cycle 6.
  - nop/illegal: rsp_valid cycle 1.
- Throughput: one command in flight; cmd_ready low from the handshake until the response is taken.

Test Plan:
- Reset, then cmd a=8'hFF b=8'h01 op=001 -> alu_start high exactly cycles 1-2, rsp_valid cycle 3, rsp_result=16'h0100, rsp_err=0, no second tinyalu launch.
- cmd a=8'hFF b=8'hFF op=100 -> rsp_valid cycle 6, rsp_result=16'hFE01. Back-to-back and a=8'hF0 b=8'h3C op=010 -> 16'h0030; xor op=011 a=8'hAA b=8'h55 -> 16'h00FF.
- rsp_ready held low 4 cycles after rsp_valid -> rsp_result/rsp_err stable, cmd_ready=0 throughout; rsp_ready=1 -> rsp_valid drops next cycle, cmd_ready=1.
- op=000 -> rsp_valid cycle 1, result 0, err 0, alu_start never high. op=111 -> result 0, err 1, err_count 0->1.
- alu_done tied 0, op=001 -> alu_start high TIMEOUT cycles then low, response err=1 result 0. Repeat 256 times with ERR_CNT_W=8 -> err_count saturates at 8'hFF.
- Assert reset_n low mid-ISSUE of a mul -> alu_start, rsp_valid, and busy go 0 immediately (asynchronously); after release no response appears and the next add completes correctly.
